// File: rtl/wb_regfile.sv
// wb_regfile -- write-back stage register file with branch redirect/flush control.
//
// Holds x1..x31 (x0 hard-wired to zero), performs the memory-stage write-back,
// turns a taken branch into a one-cycle redirect pulse followed by a
// FLUSH_CYCLES-long write-squash window, and counts retired writes.
//
// Optional feature: define WB_REGFILE_BYPASS_EN to forward a same-cycle write
// to the read ports (write-before-read). Without it reads see the old value.
//
// Ports
//   CLK, RESET            clock, asynchronous active-low reset
//   rd_i, res_i, wb_en_i  write-back index, data, request
//   take_branch_i         branch taken in memory stage
//   branch_offset_i, PC_i branch offset and PC of the branching instruction
//   stall                 global pipeline stall (freezes all state)
//   rs1_addr, rs2_addr    decode-stage read indices
//   rs1_data, rs2_data    combinational read data
//   redirect_valid        one-cycle (longer if stalled) fetch redirect request
//   redirect_pc           redirect target
//   flushing              high while writes are being squashed
//   instret               count of performed register writes
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | normal write-back, taken branch starts a redirect
// REDIRECT | redirect_valid asserted, target in redirect_pc
// FLUSH    | writes squashed, flush counter running down to 1
module wb_regfile #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  rd_i,
    input  logic [31:0] res_i,
    input  logic        wb_en_i,
    input  logic        take_branch_i,
    input  logic [31:0] branch_offset_i,
    input  logic [31:0] PC_i,
    input  logic        stall,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flushing,
    output logic [63:0] instret
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  flush_cnt, flush_cnt_nxt;
    logic        load_target;
    logic        wr_en;
    logic [31:0] regs [1:31];

    // The branching instruction itself still writes back; only FLUSH squashes.
    assign wr_en = wb_en_i && !stall && (rd_i != 5'd0) && (state != FLUSH);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            flush_cnt   <= 3'd0;
            redirect_pc <= 32'd0;
            instret     <= 64'd0;
            for (int i = 1; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            if (load_target) begin
                redirect_pc <= PC_i + branch_offset_i;
            end
            if (wr_en) begin
                regs[rd_i] <= res_i;
                instret    <= instret + 64'd1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        load_target   = 1'b0;
        if (!stall) begin
            case (state)
                IDLE: begin
                    if (take_branch_i) begin
                        state_nxt   = REDIRECT;
                        load_target = 1'b1;
                    end
                end
                REDIRECT: begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = 3'(FLUSH_CYCLES);
                end
                FLUSH: begin
                    flush_cnt_nxt = flush_cnt - 3'd1;
                    if (flush_cnt == 3'd1) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign redirect_valid = (state == REDIRECT);
    assign flushing       = (state == FLUSH);

    always_comb begin
        rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
        rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];
`ifdef WB_REGFILE_BYPASS_EN
        if (wr_en && (rd_i == rs1_addr)) begin
            rs1_data = res_i;
        end
        if (wr_en && (rd_i == rs2_addr)) begin
            rs2_data = res_i;
        end
`else
`endif
    end

endmodule
